// File: rtl/cpu_seq_ctl.sv
// Instruction sequencer for the 8-bit accumulator core: 8-state fetch/decode/execute with registered controls.
// Define SINGLE_STEP_EN to add a step input and a WAIT state between instructions.
module cpu_seq_ctl #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ena,
    input  logic [2:0]       opcode,
    input  logic             zero,
`ifdef SINGLE_STEP_EN
    input  logic             step,
`endif
    output logic             inc_pc,
    output logic             load_pc,
    output logic             load_acc,
    output logic             load_ir,
    output logic             rd,
    output logic             wr,
    output logic             datactl_ena,
    output logic             halt,
    output logic [CNT_W-1:0] instr_cnt
);

    localparam logic [2:0] OP_HLT  = 3'b000;
    localparam logic [2:0] OP_SKZ  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_ANDD = 3'b011;
    localparam logic [2:0] OP_XORR = 3'b100;
    localparam logic [2:0] OP_LDA  = 3'b101;
    localparam logic [2:0] OP_STO  = 3'b110;
    localparam logic [2:0] OP_JMP  = 3'b111;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_S0     = 4'd1,
        ST_S1     = 4'd2,
        ST_S2     = 4'd3,
        ST_S3     = 4'd4,
        ST_S4     = 4'd5,
        ST_S5     = 4'd6,
        ST_S6     = 4'd7,
        ST_S7     = 4'd8,
        ST_HALTED = 4'd9
`ifdef SINGLE_STEP_EN
        ,
        ST_WAIT   = 4'd10
`endif
    } state_t;

    state_t           st_q, st_d;
    logic             inc_pc_q, inc_pc_d;
    logic             load_pc_q, load_pc_d;
    logic             load_acc_q, load_acc_d;
    logic             load_ir_q, load_ir_d;
    logic             rd_q, rd_d;
    logic             wr_q, wr_d;
    logic             datactl_ena_q, datactl_ena_d;
    logic             halt_q, halt_d;
    logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;

    logic mem_rd_op;
    logic skz_taken;

    assign mem_rd_op = (opcode == OP_ADD) || (opcode == OP_ANDD) ||
                       (opcode == OP_XORR) || (opcode == OP_LDA);
    assign skz_taken = (opcode == OP_SKZ) && zero;

    always_comb begin
        st_d        = ST_IDLE;
        instr_cnt_d = instr_cnt_q;
        if (reset) begin
            st_d        = ST_IDLE;
            instr_cnt_d = '0;
        end else begin
            case (st_q)
                ST_IDLE: st_d = ena ? ST_S0 : ST_IDLE;
                ST_S0:   st_d = ST_S1;
                ST_S1:   st_d = ST_S2;
                ST_S2:   st_d = ST_S3;
                // halt_q already reflects the HLT decode latched on entry to S3
                ST_S3: begin
                    if (halt_q) begin
                        st_d        = ST_HALTED;
                        instr_cnt_d = instr_cnt_q + CNT_W'(1);
                    end else begin
                        st_d = ST_S4;
                    end
                end
                ST_S4:   st_d = ST_S5;
                ST_S5:   st_d = ST_S6;
                ST_S6:   st_d = ST_S7;
                ST_S7: begin
                    instr_cnt_d = instr_cnt_q + CNT_W'(1);
`ifdef SINGLE_STEP_EN
                    st_d = ena ? ST_WAIT : ST_IDLE;
`else
                    st_d = ena ? ST_S0 : ST_IDLE;
`endif
                end
                ST_HALTED: st_d = ST_HALTED;
`ifdef SINGLE_STEP_EN
                ST_WAIT: begin
                    if (!ena)      st_d = ST_IDLE;
                    else if (step) st_d = ST_S0;
                    else           st_d = ST_WAIT;
                end
`endif
                default: st_d = ST_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the state being entered so they are valid for that whole state.
    always_comb begin
        inc_pc_d      = 1'b0;
        load_pc_d     = 1'b0;
        load_acc_d    = 1'b0;
        load_ir_d     = 1'b0;
        rd_d          = 1'b0;
        wr_d          = 1'b0;
        datactl_ena_d = 1'b0;
        halt_d        = 1'b0;
        case (st_d)
            ST_S0: begin
                rd_d      = 1'b1;
                load_ir_d = 1'b1;
            end
            ST_S1: begin
                rd_d      = 1'b1;
                load_ir_d = 1'b1;
                inc_pc_d  = 1'b1;
            end
            ST_S3: begin
                inc_pc_d = 1'b1;
                halt_d   = (opcode == OP_HLT);
            end
            ST_S4: begin
                rd_d          = mem_rd_op;
                inc_pc_d      = skz_taken;
                load_pc_d     = (opcode == OP_JMP);
                datactl_ena_d = (opcode == OP_STO);
            end
            ST_S5: begin
                rd_d          = mem_rd_op;
                load_acc_d    = mem_rd_op;
                inc_pc_d      = skz_taken || (opcode == OP_JMP);
                load_pc_d     = (opcode == OP_JMP);
                wr_d          = (opcode == OP_STO);
                datactl_ena_d = (opcode == OP_STO);
            end
            ST_S6: begin
                rd_d          = mem_rd_op;
                datactl_ena_d = (opcode == OP_STO);
            end
            ST_HALTED: halt_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        st_q          <= st_d;
        inc_pc_q      <= inc_pc_d;
        load_pc_q     <= load_pc_d;
        load_acc_q    <= load_acc_d;
        load_ir_q     <= load_ir_d;
        rd_q          <= rd_d;
        wr_q          <= wr_d;
        datactl_ena_q <= datactl_ena_d;
        halt_q        <= halt_d;
        instr_cnt_q   <= instr_cnt_d;
    end

    assign inc_pc      = inc_pc_q;
    assign load_pc     = load_pc_q;
    assign load_acc    = load_acc_q;
    assign load_ir     = load_ir_q;
    assign rd          = rd_q;
    assign wr          = wr_q;
    assign datactl_ena = datactl_ena_q;
    assign halt        = halt_q;
    assign instr_cnt   = instr_cnt_q;

endmodule

// File: tb/tb_cpu_seq_ctl.sv
// Randomized and directed bench for cpu_seq_ctl against a phase-level reference model.
module tb_cpu_seq_ctl;

    localparam int CNT_W = 8;
    localparam int PH_IDLE = 8;
    localparam int PH_HALTED = 9;
    localparam int PH_WAIT = 10;

    logic             clk = 1'b0;
    logic             reset;
    logic             ena;
    logic [2:0]       opcode;
    logic             zero;
`ifdef SINGLE_STEP_EN
    logic             step;
`endif
    logic             inc_pc, load_pc, load_acc, load_ir, rd, wr, datactl_ena, halt;
    logic [CNT_W-1:0] instr_cnt;

    int total = 0;
    int bad = 0;

    // Reference model: instruction phase (0..7 = S0..S7), retired count, latched HLT decision.
    int               m_ph;
    int               m_cnt;
    bit               m_hlt;

    cpu_seq_ctl #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .ena         (ena),
        .opcode      (opcode),
        .zero        (zero),
`ifdef SINGLE_STEP_EN
        .step        (step),
`endif
        .inc_pc      (inc_pc),
        .load_pc     (load_pc),
        .load_acc    (load_acc),
        .load_ir     (load_ir),
        .rd          (rd),
        .wr          (wr),
        .datactl_ena (datactl_ena),
        .halt        (halt),
        .instr_cnt   (instr_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (phase %0d op %0d)", tag, obs, exp, m_ph, opcode);
        end
    endtask

    // Control vector {inc_pc,load_pc,load_acc,load_ir,rd,wr,datactl_ena,halt} for a phase.
    function automatic logic [7:0] exp_out(input int ph, input logic [2:0] op, input logic z);
        bit alu = (op >= 3'd2) && (op <= 3'd5);
        bit sto = (op == 3'd6);
        bit jmp = (op == 3'd7);
        bit skz = (op == 3'd1) && z;
        bit i = 0, lp = 0, la = 0, li = 0, r = 0, w = 0, dc = 0, h = 0;
        case (ph)
            0: begin r = 1; li = 1; end
            1: begin r = 1; li = 1; i = 1; end
            3: begin i = 1; h = (op == 3'd0); end
            4: begin r = alu; i = skz; lp = jmp; dc = sto; end
            5: begin r = alu; la = alu; i = skz | jmp; lp = jmp; w = sto; dc = sto; end
            6: begin r = alu; dc = sto; end
            PH_HALTED: h = 1;
            default: ;
        endcase
        return {i, lp, la, li, r, w, dc, h};
    endfunction

    task automatic model_step();
        if (reset) begin
            m_ph  = PH_IDLE;
            m_cnt = 0;
            m_hlt = 0;
        end else begin
            case (m_ph)
                PH_IDLE:   if (ena) m_ph = 0;
                PH_HALTED: ;
                PH_WAIT: begin
`ifdef SINGLE_STEP_EN
                    if (!ena) m_ph = PH_IDLE;
                    else if (step) m_ph = 0;
`endif
                end
                3: begin
                    if (m_hlt) begin
                        m_ph  = PH_HALTED;
                        m_cnt = (m_cnt + 1) % (1 << CNT_W);
                    end else begin
                        m_ph = 4;
                    end
                end
                7: begin
                    m_cnt = (m_cnt + 1) % (1 << CNT_W);
`ifdef SINGLE_STEP_EN
                    m_ph = ena ? PH_WAIT : PH_IDLE;
`else
                    m_ph = ena ? 0 : PH_IDLE;
`endif
                end
                default: m_ph = m_ph + 1;
            endcase
            if (m_ph == 3) m_hlt = (opcode == 3'd0);
        end
    endtask

    task automatic check_all(input string tag);
        logic [7:0] obs;
        obs = {inc_pc, load_pc, load_acc, load_ir, rd, wr, datactl_ena, halt};
        chk({tag, "_ctl"}, 32'(obs), 32'(exp_out(m_ph, opcode, zero)));
        chk({tag, "_cnt"}, 32'(instr_cnt), 32'(m_cnt));
        chk({tag, "_rdwr"}, 32'(rd & wr), 32'd0);
    endtask

    task automatic cycle(input logic rst, input logic en, input logic [2:0] op, input logic z,
                         input string tag);
        reset  = rst;
        ena    = en;
        opcode = op;
        zero   = z;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic run_instr(input logic [2:0] op, input logic z, input string tag);
        cycle(1'b1, 1'b1, op, z, {tag, "_rst"});
        for (int k = 0; k < 9; k++) begin
            cycle(1'b0, 1'b1, op, z, tag);
`ifdef SINGLE_STEP_EN
            step = (m_ph == PH_WAIT);
`endif
        end
    endtask

    initial begin
        reset  = 1'b1;
        ena    = 1'b1;
        opcode = 3'd0;
        zero   = 1'b0;
`ifdef SINGLE_STEP_EN
        step   = 1'b0;
`endif
        m_ph  = PH_IDLE;
        m_cnt = 0;
        m_hlt = 0;
        @(negedge clk);

        cycle(1'b1, 1'b1, 3'd5, 1'b0, "reset");
        chk("reset_vec", 32'({inc_pc, load_pc, load_acc, load_ir, rd, wr, datactl_ena, halt}), 32'd0);
        chk("reset_cnt", 32'(instr_cnt), 32'd0);
        cycle(1'b0, 1'b1, 3'd5, 1'b0, "first");
        chk("first_s0", 32'({rd, load_ir}), 32'b11);

        run_instr(3'd5, 1'b0, "lda");
        chk("lda_cnt", 32'(instr_cnt), 32'd1);
        run_instr(3'd6, 1'b0, "sto");
        run_instr(3'd1, 1'b1, "skz1");
        run_instr(3'd1, 1'b0, "skz0");
        run_instr(3'd2, 1'b0, "add");

        cycle(1'b1, 1'b1, 3'd0, 1'b0, "hlt_rst");
        for (int k = 0; k < 25; k++) cycle(1'b0, 1'b1, 3'd0, 1'b0, "hlt");
        chk("hlt_sticky", 32'(halt), 32'd1);
        chk("hlt_cnt", 32'(instr_cnt), 32'd1);
        cycle(1'b1, 1'b1, 3'd0, 1'b0, "hlt_clr");
        chk("hlt_cleared", 32'(halt), 32'd0);

        // JMP with ena dropped while in S2; instruction must still complete then idle.
        cycle(1'b0, 1'b1, 3'd7, 1'b0, "jmp");
        while (m_ph != 2) cycle(1'b0, 1'b1, 3'd7, 1'b0, "jmp");
        for (int k = 0; k < 8; k++) cycle(1'b0, 1'b0, 3'd7, 1'b0, "jmp_noena");
        chk("jmp_idle", 32'(m_ph), 32'(PH_IDLE));

        // Reset while in S5.
        cycle(1'b0, 1'b1, 3'd4, 1'b0, "mid");
        while (m_ph != 5) cycle(1'b0, 1'b1, 3'd4, 1'b0, "mid");
        cycle(1'b1, 1'b1, 3'd4, 1'b0, "mid_rst");
        chk("mid_rst_vec", 32'({inc_pc, load_pc, load_acc, load_ir, rd, wr, datactl_ena, halt}), 32'd0);

`ifdef SINGLE_STEP_EN
        // Controller must park in WAIT until a single-cycle step pulse.
        cycle(1'b0, 1'b1, 3'd5, 1'b0, "ss");
        while (m_ph != PH_WAIT) cycle(1'b0, 1'b1, 3'd5, 1'b0, "ss");
        for (int k = 0; k < 5; k++) cycle(1'b0, 1'b1, 3'd5, 1'b0, "ss_wait");
        step = 1'b1;
        cycle(1'b0, 1'b1, 3'd5, 1'b0, "ss_step");
        step = 1'b0;
        chk("ss_s0", 32'({rd, load_ir}), 32'b11);
`endif

        begin
            logic [2:0] op = 3'd5;
            logic       z  = 1'b0;
            for (int n = 0; n < 3000; n++) begin
                logic r, e;
                if (m_ph == 7 || m_ph == PH_IDLE || m_ph == PH_HALTED || m_ph == PH_WAIT) begin
                    op = 3'($urandom_range(0, 7));
                    if (op == 3'd0 && $urandom_range(0, 3) != 0) op = 3'd7;
                    z  = 1'($urandom_range(0, 1));
                end
                r = ($urandom_range(0, 99) < 2) || (m_ph == PH_HALTED && $urandom_range(0, 9) == 0);
                e = ($urandom_range(0, 99) < 85);
`ifdef SINGLE_STEP_EN
                step = 1'($urandom_range(0, 2) == 0);
`endif
                cycle(r, e, op, z, "rnd");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
